// File: rtl/factor_pkg.sv
// factor_pkg: shared FSM state type and width helper for the factorisation checker
package factor_pkg;
  typedef enum logic [1:0] {IDLE, MUL, DONE} fc_state_t;
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction
endpackage

// File: rtl/shift_add_mul.sv
// shift_add_mul: radix-2 shift-add multiplier over W steps (start loads i1/i2, step advances one bit, done flags the final step, acc holds the product)
module shift_add_mul
  import factor_pkg::*;
#(
  parameter int W = 5
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic           step,
  input  logic [W-1:0]   i1,
  input  logic [W-1:0]   i2,
  output logic           done,
  output logic [2*W-1:0] acc
);
  localparam int CW = clog2(W) + 1;
  logic [2*W-1:0] mcand;
  logic [W-1:0]   mplier;
  logic [CW-1:0]  cnt;
  assign done = step & (cnt == CW'(W - 1));
  always_ff @(posedge clk) begin
    if (rst) begin
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      cnt    <= '0;
    end else if (start) begin
      mcand  <= {{W{1'b0}}, i1};
      mplier <= i2;
      acc    <= '0;
      cnt    <= '0;
    end else if (step) begin
      acc    <= mplier[0] ? acc + mcand : acc;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= cnt + 1'b1;
    end
  end
endmodule

// File: rtl/factor_check_seq.sv
// factor_check_seq: valid/ready factorisation checker (in: i1,i2,a,in_valid,out_ready; out: in_ready,out_valid,o_prod,o_match,o_nontriv)
module factor_check_seq
  import factor_pkg::*;
#(
  parameter int W = 5
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [W-1:0]   i1,
  input  logic [W-1:0]   i2,
  input  logic [2*W-1:0] a,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*W-1:0] o_prod,
  output logic           o_match,
  output logic           o_nontriv
);
  fc_state_t      state;
  logic [W-1:0]   i1_q, i2_q;
  logic [2*W-1:0] tgt, acc;
  logic           start, done;
  assign in_ready  = (state == IDLE) & ~rst;
  assign start     = in_ready & in_valid;
  assign out_valid = state == DONE;
  assign o_prod    = out_valid ? acc : '0;
  assign o_match   = out_valid & (acc == tgt);
  assign o_nontriv = o_match & (i1_q > W'(1)) & (i2_q > W'(1));
  shift_add_mul #(.W(W)) u_mul (
    .clk  (clk),
    .rst  (rst),
    .start(start),
    .step (state == MUL),
    .i1   (i1),
    .i2   (i2),
    .done (done),
    .acc  (acc)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      i1_q  <= '0;
      i2_q  <= '0;
      tgt   <= '0;
    end else begin
      state <= start ? MUL :
               (state == MUL && done) ? DONE :
               (state == DONE && out_ready) ? IDLE : state;
      if (start) begin
        i1_q <= i1;
        i2_q <= i2;
        tgt  <= a;
      end
    end
  end
endmodule

// File: tb/tb_factor_check_seq.sv
// tb_factor_check_seq: directed vector table plus corner sequences for W=5 and W=8 instances
module tb_factor_check_seq;
  typedef struct {
    logic [7:0]  x, y;
    logic [15:0] t, p;
    logic        m, n;
    int          w8;
  } vec_t;
  logic        clk = 0, rst = 1, out_ready = 1, sel = 0;
  logic        iv5 = 0, iv8 = 0;
  logic [4:0]  i1_5 = 0, i2_5 = 0;
  logic [9:0]  a5 = 0;
  logic [7:0]  i1_8 = 0, i2_8 = 0;
  logic [15:0] a8 = 0;
  logic        ir5, ov5, m5, n5, ir8, ov8, m8, n8;
  logic [9:0]  p5;
  logic [15:0] p8;
  logic        ir, ov, om, on;
  logic [15:0] op;
  int          checks = 0, failures = 0;
  vec_t        vecs[$];
  always #5 clk = ~clk;
  factor_check_seq #(.W(5)) dut5 (
    .clk(clk), .rst(rst), .in_valid(iv5), .in_ready(ir5), .i1(i1_5), .i2(i2_5), .a(a5),
    .out_valid(ov5), .out_ready(out_ready), .o_prod(p5), .o_match(m5), .o_nontriv(n5)
  );
  factor_check_seq #(.W(8)) dut8 (
    .clk(clk), .rst(rst), .in_valid(iv8), .in_ready(ir8), .i1(i1_8), .i2(i2_8), .a(a8),
    .out_valid(ov8), .out_ready(out_ready), .o_prod(p8), .o_match(m8), .o_nontriv(n8)
  );
  assign ir = sel ? ir8 : ir5;
  assign ov = sel ? ov8 : ov5;
  assign om = sel ? m8 : m5;
  assign on = sel ? n8 : n5;
  assign op = sel ? p8 : {6'd0, p5};
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask
  task automatic drive(input logic [7:0] x, input logic [7:0] y, input logic [15:0] t);
    if (sel) begin
      i1_8 = x; i2_8 = y; a8 = t; iv8 = 1;
    end else begin
      i1_5 = x[4:0]; i2_5 = y[4:0]; a5 = t[9:0]; iv5 = 1;
    end
  endtask
  task automatic run(input vec_t v);
    int lat;
    sel = v.w8[0];
    #1;
    chk("in_ready_before", {31'd0, ir}, 1);
    drive(v.x, v.y, v.t);
    tick;
    iv5 = 0;
    iv8 = 0;
    lat = 1;
    while (!ov && lat < 40) begin
      tick;
      lat++;
    end
    chk("latency", lat, sel ? 9 : 6);
    chk("o_prod", {16'd0, op}, {16'd0, v.p});
    chk("o_match", {31'd0, om}, {31'd0, v.m});
    chk("o_nontriv", {31'd0, on}, {31'd0, v.n});
    tick;
    chk("idle_in_ready", {31'd0, ir}, 1);
    chk("idle_out_valid", {31'd0, ov}, 0);
  endtask
  initial begin
    vec_t r;
    vecs.push_back('{3, 7, 21, 21, 1, 1, 0});
    vecs.push_back('{1, 21, 21, 21, 1, 0, 0});
    vecs.push_back('{0, 9, 0, 0, 1, 0, 0});
    vecs.push_back('{31, 31, 960, 961, 0, 0, 0});
    vecs.push_back('{2, 16, 32, 32, 1, 1, 0});
    vecs.push_back('{5, 6, 31, 30, 0, 0, 0});
    vecs.push_back('{9, 0, 1, 0, 0, 0, 0});
    vecs.push_back('{31, 1, 31, 31, 1, 0, 0});
    vecs.push_back('{255, 255, 65025, 65025, 1, 1, 1});
    vecs.push_back('{16, 16, 256, 256, 1, 1, 1});
    vecs.push_back('{0, 200, 1, 0, 0, 0, 1});
    tick;
    tick;
    chk("rst_in_ready", {31'd0, ir5}, 0);
    chk("rst_out_valid", {31'd0, ov5}, 0);
    chk("rst_o_prod", {22'd0, p5}, 0);
    chk("rst_o_match", {31'd0, m5}, 0);
    chk("rst_o_nontriv", {31'd0, n5}, 0);
    rst = 0;
    #1;
    chk("post_rst_in_ready", {31'd0, ir5}, 1);
    foreach (vecs[k]) run(vecs[k]);
    sel = 0;
    out_ready = 0;
    drive(6, 5, 30);
    tick;
    iv5 = 0;
    for (int k = 0; k < 40 && !ov5; k++) tick;
    chk("bp_reach_done", {31'd0, ov5}, 1);
    for (int k = 0; k < 10; k++) begin
      iv5 = k[0];
      i1_5 = 5'(k);
      i2_5 = 5'(k + 3);
      a5 = 10'(k);
      tick;
      chk("bp_out_valid", {31'd0, ov5}, 1);
      chk("bp_o_prod", {22'd0, p5}, 30);
      chk("bp_o_match", {31'd0, m5}, 1);
      chk("bp_o_nontriv", {31'd0, n5}, 1);
      chk("bp_in_ready", {31'd0, ir5}, 0);
    end
    iv5 = 0;
    out_ready = 1;
    tick;
    chk("bp_release_idle", {31'd0, ir5}, 1);
    chk("bp_release_ov", {31'd0, ov5}, 0);
    drive(7, 9, 63);
    tick;
    iv5 = 0;
    tick;
    tick;
    rst = 1;
    tick;
    rst = 0;
    #1;
    chk("midrst_out_valid", {31'd0, ov5}, 0);
    chk("midrst_o_prod", {22'd0, p5}, 0);
    chk("midrst_in_ready", {31'd0, ir5}, 1);
    run('{5, 6, 30, 30, 1, 1, 0});
    for (int k = 0; k < 24; k++) begin
      r.x = 8'($urandom_range(0, 255));
      r.y = 8'($urandom_range(0, 255));
      r.p = 16'(r.x) * 16'(r.y);
      r.t = $urandom_range(0, 1) ? r.p : r.p + 16'd1;
      r.m = r.t == r.p;
      r.n = r.m && r.x > 1 && r.y > 1;
      r.w8 = 1;
      run(r);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
